// File: rtl/lsq_pkg.sv
// lsq_pkg: shared widths, entry record and sequencer states for the load/store queue
package lsq_pkg;
    localparam int LSQ_ROB_W = 5;
    localparam int LSQ_XLEN  = 64;
    typedef struct packed {
        logic                 is_load;
        logic                 valid_pc;
        logic [LSQ_XLEN-1:0]  pc;
        logic [LSQ_ROB_W-1:0] rob;
        logic                 valid_addr;
        logic [LSQ_XLEN-1:0]  addr;
        logic                 valid_val;
        logic [LSQ_XLEN-1:0]  val;
        logic                 committed;
    } lsq_entry_t;
    typedef enum logic [1:0] {IDLE, REQ, DONE} lsq_state_e;
endpackage

// File: rtl/lsq_entry.sv
// lsq_entry: one queue slot; alloc/addr/val/commit field groups with tag-matched fills
//  ports: clk, reset (async), flush/clear (drop slot), alloc + is_load/pc/rob (new entry),
//  addr_wr_*/val_wr_*/commit_* (tag broadcasts), q (slot contents; valid_pc marks it live)
module lsq_entry
    import lsq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 clear,
    input  logic                 alloc,
    input  logic                 is_load,
    input  logic [LSQ_XLEN-1:0]  pc,
    input  logic [LSQ_ROB_W-1:0] rob,
    input  logic                 addr_wr_en,
    input  logic [LSQ_ROB_W-1:0] addr_wr_rob,
    input  logic [LSQ_XLEN-1:0]  addr_wr_data,
    input  logic                 val_wr_en,
    input  logic [LSQ_ROB_W-1:0] val_wr_rob,
    input  logic [LSQ_XLEN-1:0]  val_wr_data,
    input  logic                 commit_valid,
    input  logic [LSQ_ROB_W-1:0] commit_rob,
    output lsq_entry_t           q
);
    logic addr_hit, val_hit, commit_hit;
    // only a slot that is already live can match, so a same-cycle alloc misses the broadcast
    assign addr_hit   = q.valid_pc && addr_wr_en && q.rob == addr_wr_rob;
    assign val_hit    = q.valid_pc && val_wr_en && q.rob == val_wr_rob;
    assign commit_hit = q.valid_pc && commit_valid && q.rob == commit_rob;
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush || clear) begin
            q <= '0;
        end else if (alloc) begin
            q <= '{is_load: is_load, valid_pc: 1'b1, pc: pc, rob: rob, default: '0};
        end else begin
            if (addr_hit) begin
                q.valid_addr <= 1'b1;
                q.addr       <= addr_wr_data;
            end
            if (val_hit) begin
                q.valid_val <= 1'b1;
                q.val       <= val_wr_data;
            end
            if (commit_hit) q.committed <= 1'b1;
        end
    end
endmodule

// File: rtl/lsq_controller.sv
// lsq_controller: in-order load/store queue sequencer issuing the head entry to data memory
//  ports: clk, reset (async); flush; alloc_* (dispatch, alloc_ready back-pressure);
//  addr_wr_*/val_wr_*/commit_* (tag broadcasts); mem_* (request/ack handshake);
//  done_* (one-cycle completion to ROB); count (occupied entries)
module lsq_controller
    import lsq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ROB_W = LSQ_ROB_W,
    parameter int XLEN  = LSQ_XLEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  logic                   alloc_is_load,
    input  logic [XLEN-1:0]        alloc_pc,
    input  logic [ROB_W-1:0]       alloc_rob,
    output logic                   alloc_ready,
    input  logic                   addr_wr_en,
    input  logic [ROB_W-1:0]       addr_wr_rob,
    input  logic [XLEN-1:0]        addr_wr_data,
    input  logic                   val_wr_en,
    input  logic [ROB_W-1:0]       val_wr_rob,
    input  logic [XLEN-1:0]        val_wr_data,
    input  logic                   commit_valid,
    input  logic [ROB_W-1:0]       commit_rob,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic                   mem_ack,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   done_valid,
    output logic [ROB_W-1:0]       done_rob,
    output logic [XLEN-1:0]        done_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] head, tail;
    lsq_state_e    state;
    lsq_entry_t    ent [DEPTH];
    lsq_entry_t    h;
    logic [XLEN-1:0] data_q;
    logic do_alloc, retire, head_ready, unused_pc;
    assign h           = ent[head];
    assign unused_pc   = ^h.pc;
    assign alloc_ready = count != CW'(DEPTH);
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign retire      = state == DONE;
    assign head_ready  = count != '0 && h.valid_pc && h.valid_addr && (h.is_load || (h.valid_val && h.committed));
    assign mem_req     = state == REQ;
    assign done_valid  = state == DONE;
    assign done_rob    = done_valid ? h.rob : '0;
    assign done_data   = done_valid ? data_q : '0;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        lsq_entry u_entry (
            .clk(clk), .reset(reset), .flush(flush),
            .clear(retire && head == PW'(i)),
            .alloc(do_alloc && tail == PW'(i)),
            .is_load(alloc_is_load), .pc(alloc_pc), .rob(alloc_rob),
            .addr_wr_en(addr_wr_en), .addr_wr_rob(addr_wr_rob), .addr_wr_data(addr_wr_data),
            .val_wr_en(val_wr_en), .val_wr_rob(val_wr_rob), .val_wr_data(val_wr_data),
            .commit_valid(commit_valid), .commit_rob(commit_rob),
            .q(ent[i])
        );
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            data_q    <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
        end else begin
            tail  <= tail + PW'(do_alloc);
            head  <= head + PW'(retire);
            count <= count + CW'(do_alloc) - CW'(retire);
            // operands are captured on issue so they stay stable while waiting for ack
            if (state == IDLE && head_ready) begin
                state     <= REQ;
                mem_we    <= !h.is_load;
                mem_addr  <= h.addr;
                mem_wdata <= h.is_load ? '0 : h.val;
            end
            if (state == REQ && mem_ack) begin
                state  <= DONE;
                data_q <= mem_we ? '0 : mem_rdata;
            end
            if (state == DONE) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_lsq_controller.sv
// tb_lsq_controller: directed scenarios plus randomized traffic against a queue-based model
module tb_lsq_controller;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        alloc_valid = 1'b0, alloc_is_load = 1'b0, alloc_ready;
    logic [63:0] alloc_pc = '0;
    logic [4:0]  alloc_rob = '0;
    logic        addr_wr_en = 1'b0, val_wr_en = 1'b0, commit_valid = 1'b0;
    logic [4:0]  addr_wr_rob = '0, val_wr_rob = '0, commit_rob = '0;
    logic [63:0] addr_wr_data = '0, val_wr_data = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0, done_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = '0, done_data;
    logic [4:0]  done_rob;
    logic [3:0]  count;
    int tests = 0, fails = 0;

    typedef struct {
        bit ld; logic [63:0] pc; logic [4:0] rob;
        bit ha; logic [63:0] a; bit hv; logic [63:0] v; bit c;
    } me_t;

    lsq_controller dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_is_load(alloc_is_load), .alloc_pc(alloc_pc),
        .alloc_rob(alloc_rob), .alloc_ready(alloc_ready),
        .addr_wr_en(addr_wr_en), .addr_wr_rob(addr_wr_rob), .addr_wr_data(addr_wr_data),
        .val_wr_en(val_wr_en), .val_wr_rob(val_wr_rob), .val_wr_data(val_wr_data),
        .commit_valid(commit_valid), .commit_rob(commit_rob),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done_valid(done_valid), .done_rob(done_rob), .done_data(done_data), .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit rdy(me_t e);
        return e.ha && (e.ld || (e.hv && e.c));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input bit ld, input logic [63:0] pc, input logic [4:0] rob);
        alloc_valid = 1'b1; alloc_is_load = ld; alloc_pc = pc; alloc_rob = rob;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic addr_wr(input logic [4:0] rob, input logic [63:0] a);
        addr_wr_en = 1'b1; addr_wr_rob = rob; addr_wr_data = a;
        tick();
        addr_wr_en = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL %s wait_req: mem_req=%b required 1 within 20 cycles", tag, mem_req);
        end
    endtask

    // waits for the request, checks operands, acks after 'hold' extra cycles and checks the done pulse
    task automatic issue(input logic [4:0] rob, input logic [63:0] a, input bit we,
                         input logic [63:0] wd, input logic [63:0] rd, input int hold);
        logic [63:0] exp_d;
        exp_d = we ? 64'd0 : rd;
        wait_req($sformatf("issue_rob%0d", rob));
        tests++;
        if ({mem_we, mem_addr, mem_wdata} !== {we, a, wd}) begin
            fails++;
            $display("FAIL issue_ops rob=%0d: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                     rob, mem_we, mem_addr, mem_wdata, we, a, wd);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== a) begin
                fails++;
                $display("FAIL issue_hold rob=%0d: req=%b addr=%h required req=1 addr=%h", rob, mem_req, mem_addr, a);
            end
        end
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        tests++;
        if (done_valid !== 1'b1 || done_rob !== rob || done_data !== exp_d) begin
            fails++;
            $display("FAIL issue_done: valid=%b rob=%0d data=%h required valid=1 rob=%0d data=%h",
                     done_valid, done_rob, done_data, rob, exp_d);
        end
        tick();
        tests++;
        if (done_valid !== 1'b0) begin
            fails++;
            $display("FAIL issue_done_pulse rob=%0d: done_valid=%b required 0", rob, done_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, done_valid, done_rob, done_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h done=%b rob=%0d data=%h required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, done_valid, done_rob, done_data);
        end
        tests++;
        if (alloc_ready !== 1'b1 || count !== 4'd0) begin
            fails++;
            $display("FAIL reset_count: ready=%b count=%0d required ready=1 count=0", alloc_ready, count);
        end
    endtask

    task automatic test_load();
        alloc(1'b1, 64'h100, 5'd3);
        tests++;
        if (count !== 4'd1) begin fails++; $display("FAIL load_count1: count=%0d required 1", count); end
        addr_wr(5'd3, 64'h2000);
        issue(5'd3, 64'h2000, 1'b0, 64'd0, 64'hAB, 2);
        tests++;
        if (count !== 4'd0) begin fails++; $display("FAIL load_count0: count=%0d required 0", count); end
    endtask

    task automatic test_store_commit();
        alloc(1'b0, 64'h200, 5'd5);
        addr_wr_en = 1'b1; addr_wr_rob = 5'd5; addr_wr_data = 64'h40;
        val_wr_en = 1'b1; val_wr_rob = 5'd5; val_wr_data = 64'h77;
        tick();
        addr_wr_en = 1'b0; val_wr_en = 1'b0;
        repeat (3) tick();
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL store_nocommit: mem_req=%b required 0", mem_req); end
        commit_valid = 1'b1; commit_rob = 5'd5;
        tick();
        commit_valid = 1'b0;
        issue(5'd5, 64'h40, 1'b1, 64'h77, 64'hDEAD, 0);
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++) alloc(1'b1, 64'h1000 + 64'(i), 5'(10 + i));
        tests++;
        if (count !== 4'd8 || alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL full: count=%0d ready=%b required count=8 ready=0", count, alloc_ready);
        end
        alloc(1'b1, 64'h0, 5'd18);
        tests++;
        if (count !== 4'd8) begin fails++; $display("FAIL full_ninth: count=%0d required 8", count); end
        addr_wr(5'd10, 64'h100A);
        wait_req("full_head");
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests++;
        if (done_valid !== 1'b1 || done_rob !== 5'd10) begin
            fails++;
            $display("FAIL full_retire: done=%b rob=%0d required done=1 rob=10", done_valid, done_rob);
        end
        alloc(1'b1, 64'h0, 5'd19);
        tests++;
        if (count !== 4'd7) begin fails++; $display("FAIL full_retire_alloc: count=%0d required 7", count); end
        alloc(1'b1, 64'h0, 5'd20);
        tests++;
        if (count !== 4'd8) begin fails++; $display("FAIL wrap_alloc: count=%0d required 8", count); end
        for (int i = 11; i <= 17; i++) addr_wr(5'(i), 64'h1000 + 64'(i));
        addr_wr(5'd20, 64'h1014);
        for (int i = 11; i <= 17; i++) issue(5'(i), 64'h1000 + 64'(i), 1'b0, 64'd0, 64'(i * 3), 0);
        issue(5'd20, 64'h1014, 1'b0, 64'd0, 64'h55, 0);
        tests++;
        if (count !== 4'd0) begin fails++; $display("FAIL wrap_drain: count=%0d required 0", count); end
    endtask

    task automatic test_out_of_order();
        alloc(1'b1, 64'h300, 5'd2);
        alloc(1'b1, 64'h304, 5'd4);
        addr_wr(5'd4, 64'h4444);
        repeat (3) tick();
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL ooo_head_wait: mem_req=%b required 0", mem_req); end
        addr_wr(5'd2, 64'h2222);
        issue(5'd2, 64'h2222, 1'b0, 64'd0, 64'h22, 0);
        issue(5'd4, 64'h4444, 1'b0, 64'd0, 64'h44, 1);
    endtask

    task automatic test_same_cycle_fill();
        alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_pc = 64'h600; alloc_rob = 5'd6;
        addr_wr_en = 1'b1; addr_wr_rob = 5'd6; addr_wr_data = 64'h6660;
        tick();
        alloc_valid = 1'b0; addr_wr_en = 1'b0;
        repeat (3) tick();
        tests++;
        if (mem_req !== 1'b0 || count !== 4'd1) begin
            fails++;
            $display("FAIL same_cycle_fill: req=%b count=%0d required req=0 count=1", mem_req, count);
        end
        addr_wr(5'd6, 64'h6666);
        issue(5'd6, 64'h6666, 1'b0, 64'd0, 64'h66, 0);
    endtask

    task automatic test_flush_reset();
        int seen;
        alloc(1'b0, 64'h700, 5'd7);
        addr_wr_en = 1'b1; addr_wr_rob = 5'd7; addr_wr_data = 64'h7000;
        val_wr_en = 1'b1; val_wr_rob = 5'd7; val_wr_data = 64'h7777;
        commit_valid = 1'b1; commit_rob = 5'd7;
        tick();
        addr_wr_en = 1'b0; val_wr_en = 1'b0; commit_valid = 1'b0;
        wait_req("flush_req");
        flush = 1'b1; mem_ack = 1'b1;
        tick();
        flush = 1'b0; mem_ack = 1'b0;
        tests++;
        if (mem_req !== 1'b0 || count !== 4'd0 || alloc_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush: req=%b count=%0d ready=%b required 0 0 1", mem_req, count, alloc_ready);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            seen += int'(done_valid);
            tick();
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL flush_no_done: done pulses=%0d required 0", seen); end
        alloc(1'b1, 64'h800, 5'd8);
        addr_wr(5'd8, 64'h8000);
        wait_req("reset_req");
        #2 reset = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL async_reset: mem_req=%b required 0", mem_req); end
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            seen += int'(done_valid);
            tick();
        end
        tests++;
        if (count !== 4'd0 || alloc_ready !== 1'b1 || seen != 0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_after: count=%0d ready=%b done=%0d req=%b required 0 1 0 0",
                     count, alloc_ready, seen, mem_req);
        end
    endtask

    task automatic test_random(input int cycles);
        me_t mq[$];
        logic [4:0] nrob;
        logic [63:0] exp_d;
        bit prev_idle, prev_ready, prev_req, pop, acc, own;
        int ia;
        nrob = 5'd0; exp_d = '0;
        prev_idle = 1'b1; prev_ready = 1'b0; prev_req = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tests++;
            if (count !== 4'(mq.size()) || alloc_ready !== (mq.size() < 8)) begin
                fails++;
                $display("FAIL rand_count c=%0d: count=%0d ready=%b required count=%0d", c, count, alloc_ready, mq.size());
            end
            if (prev_idle) begin
                tests++;
                if (mem_req !== prev_ready) begin
                    fails++;
                    $display("FAIL rand_issue c=%0d: mem_req=%b required %b", c, mem_req, prev_ready);
                end
            end
            if (mem_req && !prev_req) begin
                tests++;
                if (mq.size() == 0 || {mem_we, mem_addr, mem_wdata} !== {!mq[0].ld, mq[0].a, mq[0].ld ? 64'd0 : mq[0].v}) begin
                    fails++;
                    $display("FAIL rand_ops c=%0d: we=%b addr=%h wdata=%h required head rob=%0d addr=%h",
                             c, mem_we, mem_addr, mem_wdata, mq.size() ? mq[0].rob : 5'd0, mq.size() ? mq[0].a : 64'd0);
                end
            end
            pop = done_valid;
            if (done_valid) begin
                tests++;
                if (mq.size() == 0 || done_rob !== mq[0].rob || done_data !== exp_d) begin
                    fails++;
                    $display("FAIL rand_done c=%0d: rob=%0d data=%h required rob=%0d data=%h",
                             c, done_rob, done_data, mq.size() ? mq[0].rob : 5'd0, exp_d);
                end
            end
            prev_idle = !mem_req && !done_valid;
            prev_req = mem_req;
            acc = alloc_ready;
            flush = $urandom_range(99) == 0;
            alloc_valid = $urandom_range(1) == 1;
            alloc_is_load = $urandom_range(1) == 1;
            alloc_pc = {$urandom, $urandom};
            alloc_rob = nrob;
            // broadcasts hit an unfilled live entry, or a tag that is not live (possibly the one being allocated)
            ia = mq.size() ? $urandom_range(mq.size() - 1) : 0;
            own = mq.size() > 0 && $urandom_range(3) != 0;
            addr_wr_en = $urandom_range(2) == 0 && !(own && mq[ia].ha);
            addr_wr_rob = own ? mq[ia].rob : nrob + 5'($urandom_range(23));
            addr_wr_data = {$urandom, $urandom};
            ia = mq.size() ? $urandom_range(mq.size() - 1) : 0;
            own = mq.size() > 0 && $urandom_range(3) != 0;
            val_wr_en = $urandom_range(2) == 0 && !(own && mq[ia].hv);
            val_wr_rob = own ? mq[ia].rob : nrob + 5'($urandom_range(23));
            val_wr_data = {$urandom, $urandom};
            ia = mq.size() ? $urandom_range(mq.size() - 1) : 0;
            commit_valid = $urandom_range(2) == 0;
            commit_rob = mq.size() ? mq[ia].rob : nrob + 5'($urandom_range(23));
            mem_ack = mem_req && $urandom_range(1) == 1;
            mem_rdata = {$urandom, $urandom};
            if (mem_ack) exp_d = mem_we ? 64'd0 : mem_rdata;
            prev_ready = !flush && mq.size() > 0 && rdy(mq[0]);
            if (flush) begin
                mq.delete();
            end else begin
                foreach (mq[k]) begin
                    if (addr_wr_en && mq[k].rob == addr_wr_rob) begin mq[k].ha = 1'b1; mq[k].a = addr_wr_data; end
                    if (val_wr_en && mq[k].rob == val_wr_rob) begin mq[k].hv = 1'b1; mq[k].v = val_wr_data; end
                    if (commit_valid && mq[k].rob == commit_rob) mq[k].c = 1'b1;
                end
                if (pop) void'(mq.pop_front());
                if (alloc_valid && acc) begin
                    mq.push_back('{alloc_is_load, alloc_pc, alloc_rob, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0});
                    nrob = nrob + 5'd1;
                end
            end
            tick();
        end
        {flush, alloc_valid, addr_wr_en, val_wr_en, commit_valid, mem_ack} = '0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_commit();
        test_full_wrap();
        test_out_of_order();
        test_same_cycle_fill();
        test_flush_reset();
        test_random(3000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
